// File: rtl/mem_to_reg_mux_pkg.sv
// Purpose: shared datapath constants for the write-back path and the control decoder.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
//
// Contents:
//   XLEN        - architectural register width, default for datapath WIDTH parameters
//   WB_SEL_ALU  - mem_to_reg encoding that selects the ALU result
//   WB_SEL_MEM  - mem_to_reg encoding that selects data-memory read data
package mem_to_reg_mux_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage : mem_to_reg_mux_pkg

// File: rtl/mem_to_reg_mux_mux2.sv
// Purpose: generic WIDTH-bit two-input combinational multiplexer (write-back, ALU-src, PC-src).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_sel - select; 1 picks i_b, anything else (0, X, Z) picks i_a
//   i_a   - default input
//   i_b   - alternate input
//   o_y   - selected value, bit-for-bit unchanged
module mux2
  import mem_to_reg_mux_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // if/else rather than ?: so an unknown select resolves to i_a instead of
  // merging both inputs bitwise into X.
  always_comb begin
    o_y = i_a;
    if (i_sel) begin
      o_y = i_b;
    end
  end

endmodule : mux2

// File: rtl/mem_to_reg_mux.sv
// Purpose: write-back source selector; registers ALU result or memory read data for the regfile.
// Latency: one clock from inputs sampled at a rising edge to selected.
// Backpressure: none; no handshake or stall, a new value is captured every edge.
//
// Ports:
//   clk        - system clock, rising edge active
//   mem_to_reg - 1 selects mem_data, otherwise alu_result
//   alu_result - ALU output for the current instruction
//   mem_data   - data-memory read data for the current instruction
//   selected   - registered write-back value
//   rst        - synchronous active-high reset, highest priority, clears selected
module mem_to_reg_mux
  import mem_to_reg_mux_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             mem_to_reg,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] selected,
  // Last so five-port positional instantiations remain valid.
  input  logic             rst
);

  logic             w_sel_mem;
  logic [WIDTH-1:0] w_wb_dat;
  logic [WIDTH-1:0] r_selected;

  // Only an explicit WB_SEL_MEM picks memory; an X/Z select compares to X,
  // which the mux treats as false, so the ALU path stays the default.
  assign w_sel_mem = (mem_to_reg == WB_SEL_MEM);

  mux2 #(
    .WIDTH(WIDTH)
  ) u_wb_mux (
    .i_sel(w_sel_mem),
    .i_a  (alu_result),
    .i_b  (mem_data),
    .o_y  (w_wb_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_selected <= '0;
    end else begin
      r_selected <= w_wb_dat;
    end
  end

  assign selected = r_selected;

endmodule : mem_to_reg_mux

// File: tb/tb_mem_to_reg_mux.sv
// Purpose: directed self-checking bench for mem_to_reg_mux.
// Latency: expects selected one edge after the inputs it reflects.
// Backpressure: n/a.
module tb_mem_to_reg_mux;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         mem_to_reg;
  logic [W-1:0] alu_result;
  logic [W-1:0] mem_data;
  logic [W-1:0] selected;

  int n_cmp;
  int n_err;

  mem_to_reg_mux #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .mem_to_reg(mem_to_reg),
    .alu_result(alu_result),
    .mem_data  (mem_data),
    .selected  (selected),
    .rst       (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Alternation vectors: select per edge, reset per edge, hand-computed result.
  logic         alt_sel [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic         alt_rst [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [W-1:0] alt_exp [8] = '{32'h1234_5678, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321,
                                32'h0000_0000, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321};

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held for two edges with memory selected.
    rst        = 1'b1;
    alu_result = 32'd15;
    mem_data   = 32'd20;
    mem_to_reg = 1'b1;
    tick();
    chk("reset_edge1", selected, 32'd0);
    tick();
    chk("reset_edge2", selected, 32'd0);
    rst = 1'b0;
    tick();
    chk("reset_release_mem", selected, 32'd20);

    // ALU select.
    mem_to_reg = 1'b0;
    tick();
    chk("alu_select", selected, 32'd15);

    // Memory select, not visible before the edge.
    mem_to_reg = 1'b1;
    #3;
    chk("mem_not_early", selected, 32'd15);
    tick();
    chk("mem_select", selected, 32'd20);

    // Undriven select falls back to the ALU.
    mem_to_reg = 1'bx;
    alu_result = 32'd15;
    tick();
    chk("sel_x_alu", selected, 32'd15);

    // Full-width pass-through on both paths.
    mem_to_reg = 1'b0;
    alu_result = 32'hFFFF_FFFF;
    tick();
    chk("alu_full_width", selected, 32'hFFFF_FFFF);
    mem_to_reg = 1'b1;
    mem_data   = 32'hA5A5_5A5A;
    tick();
    chk("mem_full_width", selected, 32'hA5A5_5A5A);

    // Select glitch between edges: only the value at the edge counts.
    mem_to_reg = 1'b0;
    alu_result = 32'h0000_0001;
    #2;
    mem_to_reg = 1'b1;
    #2;
    mem_to_reg = 1'b0;
    tick();
    chk("sel_glitch_alu", selected, 32'h0000_0001);

    // Alternating select with a single-edge reset in the middle.
    alu_result = 32'h1234_5678;
    mem_data   = 32'h8765_4321;
    for (int i = 0; i < 8; i++) begin
      mem_to_reg = alt_sel[i];
      rst        = alt_rst[i];
      tick();
      chk($sformatf("alternate_%0d", i), selected, alt_exp[i]);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_to_reg_mux
